// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants for the two-way demultiplexer
package demux_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux_two_way_if.sv
// rtl/demux_two_way_if.sv - input stream, two output streams and word counters
interface demux_two_way_if #(
    parameter int WIDTH = demux_pkg::WIDTH_DEF,
    parameter int CNT_W = demux_pkg::CNT_W_DEF
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - per-channel FIFO with separate occupancy count, zero data when empty
module demux_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == OCC_W'(DEPTH));
    // A full FIFO refuses the push even if it pops in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + OCC_W'(1);
        else if (do_pop && !do_push) count_d = count_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/demux_two_way.sv
// rtl/demux_two_way.sv - steers each input word by select bit into one of two buffered channels
module demux_two_way
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    demux_two_way_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             push0, push1;
    logic             full0, full1;
    logic             empty0, empty1;
    logic [OCC_W-1:0] occ0, occ1;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Ready depends only on the selected channel's registered occupancy.
    assign bus.in_ready = (bus.in_sel == CH1) ? !full1 : !full0;
    assign push0 = bus.in_valid && bus.in_ready && (bus.in_sel == CH0);
    assign push1 = bus.in_valid && bus.in_ready && (bus.in_sel == CH1);

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push0),
        .data_i  (bus.in_data),
        .pop_i   (bus.out0_ready),
        .data_o  (bus.out0_data),
        .count_o (occ0),
        .empty_o (empty0),
        .full_o  (full0)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push1),
        .data_i  (bus.in_data),
        .pop_i   (bus.out1_ready),
        .data_o  (bus.out1_data),
        .count_o (occ1),
        .empty_o (empty1),
        .full_o  (full1)
    );

    assign bus.out0_valid = (occ0 != '0);
    assign bus.out1_valid = (occ1 != '0);

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0) cnt0_d = cnt0_q + CNT_W'(1);
        if (push1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_two_way.sv
// tb/tb_demux_two_way.sv - directed stimulus with queue-based reference model
module tb_demux_two_way;
    localparam int W  = 4;
    localparam int D  = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_two_way_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    demux_two_way #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0]  q0[$];
    logic [W-1:0]  q1[$];
    logic [CW-1:0] m_cnt0 = '0;
    logic [CW-1:0] m_cnt1 = '0;
    bit            started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            m_cnt0  <= '0;
            m_cnt1  <= '0;
            started <= 1;
        end else if (started) begin
            automatic bit pop0 = bus.out0_ready && (q0.size() > 0);
            automatic bit pop1 = bus.out1_ready && (q1.size() > 0);
            automatic bit acc  = bus.in_valid &&
                                 ((bus.in_sel ? q1.size() : q0.size()) < D);
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (acc) begin
                if (bus.in_sel) begin
                    q1.push_back(bus.in_data);
                    m_cnt1 <= m_cnt1 + 1'b1;
                end else begin
                    q0.push_back(bus.in_data);
                    m_cnt0 <= m_cnt0 + 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_in_ready", 32'(bus.in_ready),
                  32'((bus.in_sel ? q1.size() : q0.size()) < D));
            check("m_out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
            check("m_out0_data", 32'(bus.out0_data), 32'(q0.size() != 0 ? q0[0] : 4'h0));
            check("m_out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
            check("m_out1_data", 32'(bus.out1_data), 32'(q1.size() != 0 ? q1[0] : 4'h0));
            check("m_cnt0", 32'(bus.cnt0), 32'(m_cnt0));
            check("m_cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0);
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("rst_out0_data", 32'(bus.out0_data), 32'd0);
        check("rst_cnt0", 32'(bus.cnt0), 32'd0);
        check("rst_cnt1", 32'(bus.cnt1), 32'd0);
        rst = 1'b0;
        #1 check("rst_ready_sel0", 32'(bus.in_ready), 32'd1);
        bus.in_sel = 1'b1;
        #1 check("rst_ready_sel1", 32'(bus.in_ready), 32'd1);

        // route: 0x3 to ch0 then 0xA to ch1
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b0, 4'h3);
        step();
        check("route_out0_valid", 32'(bus.out0_valid), 32'd1);
        check("route_out0_data", 32'(bus.out0_data), 32'h3);
        drive(1'b1, 1'b1, 4'hA);
        step();
        check("route_out1_data", 32'(bus.out1_data), 32'hA);
        check("route_out0_gone", 32'(bus.out0_valid), 32'd0);
        check("route_cnt0", 32'(bus.cnt0), 32'd1);
        check("route_cnt1", 32'(bus.cnt1), 32'd1);

        // fill and stall ch0
        bus.out0_ready = 1'b0;
        drive(1'b1, 1'b0, 4'h1);
        step();
        drive(1'b1, 1'b0, 4'h2);
        step();
        drive(1'b1, 1'b0, 4'h3);
        #1 check("stall_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("stall_cnt0", 32'(bus.cnt0), 32'd3);
        check("stall_head", 32'(bus.out0_data), 32'h1);
        bus.out0_ready = 1'b1;
        step();
        check("pop_ready", 32'(bus.in_ready), 32'd1);
        check("pop_head2", 32'(bus.out0_data), 32'h2);
        check("pop_cnt0_held", 32'(bus.cnt0), 32'd3);
        step();
        check("pop_head3", 32'(bus.out0_data), 32'h3);
        check("pop_cnt0_acc", 32'(bus.cnt0), 32'd4);
        drive(1'b0, 1'b0, 4'h0);
        step();
        check("drain_out0_valid", 32'(bus.out0_valid), 32'd0);

        // independence: ch0 full and stalled, ch1 still accepts
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b0, 4'h7);
        step();
        drive(1'b1, 1'b0, 4'h8);
        step();
        drive(1'b1, 1'b1, 4'h5);
        #1 check("indep_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("indep_out1_data", 32'(bus.out1_data), 32'h5);
        check("indep_cnt1", 32'(bus.cnt1), 32'd2);
        drive(1'b0, 1'b0, 4'h0);
        step();

        // simultaneous push and pop on ch1 holding one entry
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b1, 4'h6);
        step();
        check("pp_data6", 32'(bus.out1_data), 32'h6);
        check("pp_cnt1_3", 32'(bus.cnt1), 32'd3);
        drive(1'b1, 1'b1, 4'h9);
        step();
        check("pp_data9", 32'(bus.out1_data), 32'h9);
        check("pp_cnt1_4", 32'(bus.cnt1), 32'd4);
        drive(1'b0, 1'b0, 4'h0);
        bus.out1_ready = 1'b0;
        step();

        // mid-operation reset with both channels holding data
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'hF);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0);
        check("mr_out0_valid", 32'(bus.out0_valid), 32'd0);
        check("mr_out1_valid", 32'(bus.out1_valid), 32'd0);
        check("mr_out0_data", 32'(bus.out0_data), 32'd0);
        check("mr_out1_data", 32'(bus.out1_data), 32'd0);
        check("mr_cnt0", 32'(bus.cnt0), 32'd0);
        check("mr_cnt1", 32'(bus.cnt1), 32'd0);
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        repeat (3) step();
        check("mr_no_ghost", 32'({bus.out0_valid, bus.out1_valid}), 32'd0);

        // counter wrap on ch0
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 4'(i));
            step();
            if (i == 254) check("wrap_cnt0_ff", 32'(bus.cnt0), 32'hFF);
        end
        drive(1'b0, 1'b0, 4'h0);
        check("wrap_cnt0_zero", 32'(bus.cnt0), 32'h00);
        check("wrap_cnt1_same", 32'(bus.cnt1), 32'h00);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
